// File: rtl/vga_dac_palette_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module  : vga_dac_palette_if
// | Purpose : Video lookup and CPU I/O bus bundle for the palette DAC.
// | Rev     : 1.0
// +----------------------------------------------------------------------------
interface vga_dac_palette_if;
  logic [7:0]  dac_a;
  logic [11:0] dac_q;
  logic [15:0] port_a;
  logic [7:0]  port_o;
  logic        port_w;
  logic        port_r;
  logic [7:0]  port_i;
  logic        busy;

  modport master (
    output dac_a, port_a, port_o, port_w, port_r,
    input  dac_q, port_i, busy
  );

  modport slave (
    input  dac_a, port_a, port_o, port_w, port_r,
    output dac_q, port_i, busy
  );
endinterface
`default_nettype wire

// File: rtl/vga_dac_palette.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module  : vga_dac_palette
// | Purpose : 256x12 palette RAM with video lookup, 3C6..3C9 CPU ports, CGA loader.
// | Rev     : 1.0
// +----------------------------------------------------------------------------
module vga_dac_palette #(
  parameter bit          INIT_DEFAULT = 1'b1,
  parameter logic [15:0] PORT_BASE    = 16'h03C0
) (
  input  wire logic       clock,
  input  wire logic       reset_n,
  vga_dac_palette_if.slave bus
);

  localparam logic [0:0] c_S_INIT  = 1'b0;
  localparam logic [0:0] c_S_IDLE  = 1'b1;
  localparam logic [1:0] c_MODE_RD = 2'd0;
  localparam logic [1:0] c_MODE_WR = 2'd3;

  function automatic logic [11:0] f_cga(input logic [3:0] i);
    case (i)
      4'd0:  f_cga = 12'h000;
      4'd1:  f_cga = 12'h00A;
      4'd2:  f_cga = 12'h0A0;
      4'd3:  f_cga = 12'h0AA;
      4'd4:  f_cga = 12'hA00;
      4'd5:  f_cga = 12'hA0A;
      4'd6:  f_cga = 12'hA50;
      4'd7:  f_cga = 12'hAAA;
      4'd8:  f_cga = 12'h555;
      4'd9:  f_cga = 12'h55F;
      4'd10: f_cga = 12'h5F5;
      4'd11: f_cga = 12'h5FF;
      4'd12: f_cga = 12'hF55;
      4'd13: f_cga = 12'hF5F;
      4'd14: f_cga = 12'hFF5;
      default: f_cga = 12'hFFF;
    endcase
  endfunction

  logic [11:0] r_ram [0:255];
  logic [0:0]  r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_ld_we, w_cpu_en, w_busy;
  logic [7:0]  r_mask, r_widx, r_ridx, r_port_i;
  logic [1:0]  r_wphase, r_rphase, r_mode;
  logic [3:0]  r_r4, r_g4;
  logic [11:0] r_dac_q;

  logic        w_hit_mask, w_hit_ridx, w_hit_widx, w_hit_data;
  logic        w_wr, w_rd;
  logic        w_ram_we;
  logic [7:0]  w_ram_addr;
  logic [11:0] w_ram_wd, w_ram_rd;
  logic [3:0]  w_comp;
  logic [7:0]  w_rd_data;

  // Loader FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INIT_DEFAULT ? c_S_INIT : c_S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == c_S_INIT) begin
      w_cnt_nxt = r_cnt + 4'd1;
      if (r_cnt == 4'd15) w_state_nxt = c_S_IDLE;
    end
  end

  always_comb begin
    w_ld_we  = (r_state == c_S_INIT);
    w_busy   = (r_state == c_S_INIT);
    w_cpu_en = (r_state == c_S_IDLE);
  end

  assign w_hit_mask = (bus.port_a == PORT_BASE + 16'd6);
  assign w_hit_ridx = (bus.port_a == PORT_BASE + 16'd7);
  assign w_hit_widx = (bus.port_a == PORT_BASE + 16'd8);
  assign w_hit_data = (bus.port_a == PORT_BASE + 16'd9);
  assign w_wr       = bus.port_w && w_cpu_en;
  // A simultaneous write wins; the read is dropped even if the write itself is dropped.
  assign w_rd       = bus.port_r && !bus.port_w;

  always_comb begin
    w_ram_we   = w_ld_we || (w_wr && w_hit_data && (r_wphase == 2'd2));
    w_ram_addr = w_ld_we ? {4'h0, r_cnt} : r_widx;
    w_ram_wd   = w_ld_we ? f_cga(r_cnt) : {r_r4, r_g4, bus.port_o[5:2]};
  end

  always_ff @(posedge clock) begin
    if (w_ram_we) r_ram[w_ram_addr] <= w_ram_wd;
  end

  assign w_ram_rd = r_ram[r_ridx];

  always_comb begin
    case (r_rphase)
      2'd0:    w_comp = w_ram_rd[11:8];
      2'd1:    w_comp = w_ram_rd[7:4];
      default: w_comp = w_ram_rd[3:0];
    endcase
    w_rd_data = 8'h00;
    if (w_hit_mask)      w_rd_data = r_mask;
    else if (w_hit_ridx) w_rd_data = {6'b0, r_mode};
    else if (w_hit_widx) w_rd_data = r_widx;
    else if (w_hit_data) w_rd_data = {2'b00, w_comp, w_comp[3:2]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mask   <= 8'hFF;
      r_widx   <= 8'h00;
      r_ridx   <= 8'h00;
      r_wphase <= 2'd0;
      r_rphase <= 2'd0;
      r_mode   <= c_MODE_WR;
      r_r4     <= 4'h0;
      r_g4     <= 4'h0;
      r_port_i <= 8'h00;
      r_dac_q  <= 12'h000;
    end else begin
      r_dac_q <= r_ram[bus.dac_a & r_mask];
      if (w_wr) begin
        if (w_hit_mask) begin
          r_mask <= bus.port_o;
        end else if (w_hit_ridx) begin
          r_ridx   <= bus.port_o;
          r_rphase <= 2'd0;
          r_mode   <= c_MODE_RD;
        end else if (w_hit_widx) begin
          r_widx   <= bus.port_o;
          r_wphase <= 2'd0;
          r_mode   <= c_MODE_WR;
        end else if (w_hit_data) begin
          case (r_wphase)
            2'd0: begin
              r_r4     <= bus.port_o[5:2];
              r_wphase <= 2'd1;
            end
            2'd1: begin
              r_g4     <= bus.port_o[5:2];
              r_wphase <= 2'd2;
            end
            default: begin
              r_widx   <= r_widx + 8'd1;
              r_wphase <= 2'd0;
            end
          endcase
        end
      end
      if (w_rd) begin
        r_port_i <= w_rd_data;
        if (w_hit_data) begin
          if (r_rphase == 2'd2) begin
            r_rphase <= 2'd0;
            r_ridx   <= r_ridx + 8'd1;
          end else begin
            r_rphase <= r_rphase + 2'd1;
          end
        end
      end
    end
  end

  assign bus.dac_q  = r_dac_q;
  assign bus.port_i = r_port_i;
  assign bus.busy   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_vga_dac_palette.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module  : tb_vga_dac_palette
// | Purpose : Scoreboard bench for the palette DAC video and CPU port paths.
// | Rev     : 1.0
// +----------------------------------------------------------------------------
module tb_vga_dac_palette;

  localparam logic [15:0] c_PB = 16'h03C0;

  typedef struct {
    string       tag;
    bit          is_dac;
    logic [11:0] exp;
  } sb_t;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  sb_t  q_sb[$];
  logic [7:0]  last_pi;
  logic [11:0] m_pal [0:255];
  logic [7:0]  rnd_idx [0:7];

  vga_dac_palette_if bus();

  vga_dac_palette #(
    .INIT_DEFAULT (1'b1),
    .PORT_BASE    (16'h03C0)
  ) u_dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop();
    sb_t e;
    if (q_sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q_sb.pop_front();
      chk(e.tag, e.is_dac ? {20'h0, bus.dac_q} : {24'h0, bus.port_i}, {20'h0, e.exp});
    end
  endtask

  task automatic io_wr(input logic [15:0] off, input logic [7:0] d);
    bus.port_a = c_PB + off;
    bus.port_o = d;
    bus.port_w = 1'b1;
    cyc();
    bus.port_w = 1'b0;
  endtask

  task automatic io_rd(input logic [15:0] off, input logic [7:0] exp, input string tag);
    bus.port_a = c_PB + off;
    bus.port_r = 1'b1;
    q_sb.push_back('{tag: tag, is_dac: 1'b0, exp: {4'h0, exp}});
    cyc();
    bus.port_r = 1'b0;
    sb_pop();
    last_pi = exp;
  endtask

  task automatic dac_rd(input logic [7:0] idx, input logic [11:0] exp, input string tag);
    bus.dac_a = idx;
    q_sb.push_back('{tag: tag, is_dac: 1'b1, exp: exp});
    cyc();
    sb_pop();
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk(tag, n, 16);
  endtask

  function automatic logic [7:0] exp6(input logic [3:0] c);
    return {2'b00, c, c[3:2]};
  endfunction

  initial begin
    bus.dac_a  = 8'h00;
    bus.port_a = 16'h0000;
    bus.port_o = 8'h00;
    bus.port_w = 1'b0;
    bus.port_r = 1'b0;
    last_pi    = 8'h00;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac_q", {20'h0, bus.dac_q}, 32'h0);
    chk("rst_port_i", {24'h0, bus.port_i}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h1);

    // Release reset and try a full data triplet while the loader is running.
    rst_n = 1'b1;
    begin
      int n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
        bus.port_a = c_PB + 16'd9;
        bus.port_o = 8'h3F;
        bus.port_w = (n >= 1 && n <= 3);
        cyc();
        n++;
      end
      bus.port_w = 1'b0;
      chk("init_len", n, 16);
    end
    dac_rd(8'd0, 12'h000, "init_drop_ram");
    io_rd(16'd8, 8'h00, "init_drop_widx");
    io_rd(16'd6, 8'hFF, "mask_rst");
    io_rd(16'd7, 8'h03, "mode_rst");
    dac_rd(8'd4, 12'hA00, "cga_4");
    dac_rd(8'd14, 12'hFF5, "cga_14");
    dac_rd(8'd15, 12'hFFF, "cga_15");

    io_wr(16'd8, 8'h20);
    io_wr(16'd9, 8'h3F);
    io_wr(16'd9, 8'h00);
    io_wr(16'd9, 8'h20);
    dac_rd(8'h20, 12'hF08, "trip_20");
    io_rd(16'd8, 8'h21, "widx_inc");

    io_wr(16'd8, 8'hFF);
    io_wr(16'd9, 8'h3C); io_wr(16'd9, 8'h30); io_wr(16'd9, 8'h24);
    io_wr(16'd9, 8'h10); io_wr(16'd9, 8'h14); io_wr(16'd9, 8'h18);
    dac_rd(8'hFF, 12'hFC9, "wrap_ff");
    dac_rd(8'h00, 12'h456, "wrap_00");
    io_rd(16'd8, 8'h01, "wrap_widx");

    io_wr(16'd8, 8'h30);
    io_wr(16'd9, 8'h3F);
    io_wr(16'd8, 8'h30);
    io_wr(16'd9, 8'h04); io_wr(16'd9, 8'h08); io_wr(16'd9, 8'h0C);
    dac_rd(8'h30, 12'h123, "partial_drop");

    io_wr(16'd7, 8'h01);
    io_rd(16'd9, 8'h00, "rd_1_r");
    io_rd(16'd9, 8'h00, "rd_1_g");
    io_rd(16'd9, 8'h2A, "rd_1_b");
    io_rd(16'd7, 8'h00, "mode_rd");
    io_rd(16'd9, 8'h00, "rd_2_r");
    io_rd(16'd9, 8'h2A, "rd_2_g");

    io_wr(16'd6, 8'h0F);
    dac_rd(8'h1C, 12'hF55, "mask_1c");
    io_rd(16'd6, 8'h0F, "mask_rd");
    io_wr(16'd6, 8'hFF);

    bus.port_a = c_PB + 16'd6;
    bus.port_o = 8'hAA;
    bus.port_w = 1'b1;
    bus.port_r = 1'b1;
    cyc();
    bus.port_w = 1'b0;
    bus.port_r = 1'b0;
    chk("wr_rd_hold", {24'h0, bus.port_i}, {24'h0, last_pi});
    io_rd(16'd6, 8'hAA, "wr_rd_mask");
    io_wr(16'd6, 8'hFF);
    io_rd(16'd5, 8'h00, "unmapped");

    // Random triplets in distinct 32-entry bands, checked through both read paths.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] r, g, b;
      rnd_idx[k] = 8'(k * 32 + $urandom_range(0, 15));
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      io_wr(16'd8, rnd_idx[k]);
      io_wr(16'd9, r); io_wr(16'd9, g); io_wr(16'd9, b);
      m_pal[rnd_idx[k]] = {r[5:2], g[5:2], b[5:2]};
    end
    for (int k = 0; k < 8; k++) begin
      logic [11:0] e;
      e = m_pal[rnd_idx[k]];
      dac_rd(rnd_idx[k], e, "rnd_dac");
      io_wr(16'd7, rnd_idx[k]);
      io_rd(16'd9, exp6(e[11:8]), "rnd_r");
      io_rd(16'd9, exp6(e[7:4]), "rnd_g");
      io_rd(16'd9, exp6(e[3:0]), "rnd_b");
    end

    io_wr(16'd8, 8'h40);
    io_wr(16'd9, 8'h3F);
    rst_n = 1'b0;
    #3;
    chk("mid_rst_busy", {31'h0, bus.busy}, 32'h1);
    chk("mid_rst_dac_q", {20'h0, bus.dac_q}, 32'h0);
    chk("mid_rst_port_i", {24'h0, bus.port_i}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("reinit_len");
    dac_rd(8'd0, 12'h000, "reinit_0");
    dac_rd(8'd15, 12'hFFF, "reinit_15");
    dac_rd(8'h30, 12'h123, "ram_kept");
    io_wr(16'd9, 8'h04); io_wr(16'd9, 8'h08); io_wr(16'd9, 8'h0C);
    dac_rd(8'd0, 12'h123, "wphase_rst");
    io_rd(16'd8, 8'h01, "widx_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_dac_palette.md
Name: vga_dac_palette

Overview:
- Palette DAC stage that sits directly upstream of the video scan-out block.
- Owns the 256x12 palette RAM.
- Serves the scan-out block's colour lookup (dac_a -> dac_q) and the CPU's VGA-style I/O ports 3C6..3C9: pixel mask, read index, write index, and data triplets.
- After reset, loads the 16 standard CGA colours into entries 0..15 so text mode is legible before software programs the palette.

Parameters:
- INIT_DEFAULT, 1, when 1 the reset-time loader writes CGA colours to entries 0..15; when 0 the loader is skipped.
- PORT_BASE, 16'h03C0, base I/O address; registers sit at PORT_BASE+6..+9.

Ports:
- clock  in  1  system clock (25 MHz pixel clock domain)
- reset_n  in  1  asynchronous active-low reset
- dac_a  in  8  palette index from the scan-out block
- dac_q  out  12  colour {R4,G4,B4}, registered
- port_a  in  16  CPU I/O address
- port_o  in  8  CPU write data
- port_w  in  1  I/O write strobe, one cycle
- port_r  in  1  I/O read strobe, one cycle
- port_i  out  8  I/O read data, registered
- busy  out  1  high while the init loader runs

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: dac_q=0, port_i=0, busy=INIT_DEFAULT, mask=8'hFF, widx=0, ridx=0, wphase=0, rphase=0, mode=write(3). RAM contents are not reset.
- Reset asserted mid-operation aborts everything, including the loader and partial triplets; the loader restarts on release.

Video path:
- dac_q <= ram[dac_a & mask] every cycle, 1-cycle latency, independent of the CPU and busy.
- If the video side reads the address being written in the same cycle, it returns the old data (read-before-write).

FSM:
- States: INIT, IDLE.
- INIT: cnt 0..15, one RAM write per cycle of the CGA table:
  000, 00A, 0A0, 0AA, A00, A0A, A50, AAA, 555, 55F, 5F5, 5FF, F55, F5F, FF5, FFF.
- After cnt=15: busy <= 0, go to IDLE. INIT therefore lasts exactly 16 cycles.
- INIT_DEFAULT=0: reset goes straight to IDLE with busy=0.
- CPU port writes during INIT are dropped. Reads are served normally.

Port writes (IDLE):
- +6: mask <= port_o.
- +7: ridx <= port_o, rphase <= 0, mode <= 0 (read).
- +8: widx <= port_o, wphase <= 0, mode <= 3 (write). Any partial triplet is discarded.
- +9:
  - wphase 0: latch R6 <= port_o[5:0].
  - wphase 1: latch G6 <= port_o[5:0].
  - wphase 2: ram[widx] <= {R6[5:2], G6[5:2], port_o[5:2]}; widx <= widx+1 (wraps 255->0); wphase <= 0.
  - port_o[7:6] are ignored.

Port reads, port_i valid the cycle after port_r:
- +6: returns mask.
- +7: returns {6'b0, mode}.
- +8: returns widx.
- +9: returns the component of ram[ridx] selected by rphase (0=R, 1=G, 2=B), expanded from 4 to 6 bits as {2'b00, c4, c4[3:2]}.
  - rphase advances on each read; after B, ridx <= ridx+1 (wraps), rphase <= 0.
- Other addresses: port_i <= 8'h00, no state change.

Simultaneous events:
- port_w and port_r together: the write is processed, the read is ignored (port_i holds, rphase unchanged).
- Strobes on unmapped addresses have no effect.
- Read and write indexes, and their phases, are fully independent.

Test Plan:
- Reset release, INIT_DEFAULT=1 -> busy high 16 cycles then low; dac_a=4 gives dac_q=12'hA00 one cycle later; dac_a=14 gives 12'hFF5.
- Write 3C8=0x20, then 3C9 = 0x3F, 0x00, 0x20 -> dac_a=0x20 gives dac_q=12'hF08; 3C8 read returns 0x21.
- Write 3C8=0xFF plus two full triplets -> entries 0xFF and 0x00 are written (wrap); widx ends at 0x01.
- Write 3C8=0x30, one 3C9 byte, then 3C8=0x30 again plus a full triplet 0x04, 0x08, 0x0C -> entry 0x30 = 12'h123; the partial byte has no effect.
- 3C7=0x01 (entry 00A), then three 3C9 reads -> port_i 0x00, 0x00, 0x2A; 3C7 read returns 0x00; the next 3C9 read returns the R component of entry 0x02.
- Mask 3C6=0x0F, dac_a=0x1C -> dac_q = entry 0x0C (F55). Also: a data write during INIT is dropped; assert reset_n mid-triplet, release -> wphase=0, loader reruns.
